// File: rtl/fifo_umbral.sv
// Synchronous FIFO for one data/virtual-channel lane, with threshold flags
// against the FSM-programmed almost-full / almost-empty levels.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [7:0]            umbral_alto,
  input  logic [7:0]            umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  error_q;

  logic                  is_full;
  logic                  is_empty;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow;
  logic                  underflow;
  logic [7:0]            count_ext;

  // Handshake: wr_en/rd_en are requests with no ready back-pressure. A write
  // is accepted when there is room (or a read frees a slot on the same edge),
  // a read when the FIFO holds a word; a refused request raises fifo_error.
  // valid_out marks the one cycle after an accepted read.
  assign is_full   = count_q[ADDR_WIDTH];
  assign is_empty  = (count_q == '0);
  assign rd_acc    = rd_en && !is_empty;
  assign wr_acc    = wr_en && (!is_full || rd_acc);
  assign overflow  = wr_en && is_full && !rd_acc;
  assign underflow = rd_en && is_empty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - 1'b1;
      end
      if (overflow || underflow) begin
        error_q <= 1'b1;
      end
    end
  end

  // Plain unsigned compares already give the threshold edge cases:
  // alto=0 -> always almost_full, alto>DEPTH -> never, bajo>=DEPTH -> always almost_empty.
  assign count_ext    = 8'(count_q);
  assign almost_full  = (count_ext >= umbral_alto);
  assign almost_empty = (count_ext <= umbral_bajo);

  assign fifo_full  = is_full;
  assign fifo_empty = is_empty;
  assign fifo_error = error_q;
  assign count      = count_q;
  assign data_out   = data_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: reset, fill, overflow, drain, underflow,
// simultaneous read/write with wrap, thresholds and asynchronous reset.
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [5:0] data_in;
  logic       rd_en;
  logic [7:0] umbral_alto;
  logic [7:0] umbral_bajo;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " empty"}, 32'(fifo_empty), 32'd1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " full"}, 32'(fifo_full), 32'd0);
    check({tag, " almost_full"}, 32'(almost_full), 32'd0);
    check({tag, " error"}, 32'(fifo_error), 32'd0);
    check({tag, " valid"}, 32'(valid_out), 32'd0);
    check({tag, " data_out"}, 32'(data_out), 32'd0);
  endtask

  logic       exp_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic       exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       exp_fu [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [5:0] exp_rw [6] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h10, 6'h11};

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    umbral_alto = 8'd3; umbral_bajo = 8'd1;
    step(); step();
    check_reset_state("reset");
    reset = 1'b1;

    // Fill 0x01..0x04
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 6'(i + 1);
      step();
      check("fill count", 32'(count), 32'(i + 1));
      check("fill almost_empty", 32'(almost_empty), 32'(exp_ae[i]));
      check("fill almost_full", 32'(almost_full), 32'(exp_af[i]));
      check("fill full", 32'(fifo_full), 32'(exp_fu[i]));
    end

    // Overflow: 0x05 dropped
    data_in = 6'h05;
    step();
    wr_en = 1'b0;
    check("ovf count", 32'(count), 32'd4);
    check("ovf error", 32'(fifo_error), 32'd1);
    check("ovf full", 32'(fifo_full), 32'd1);

    // Thresholds at count=4, combinational
    umbral_alto = 8'd5; umbral_bajo = 8'd4;
    #1;
    check("thr alto>depth", 32'(almost_full), 32'd0);
    check("thr bajo>=depth", 32'(almost_empty), 32'd1);
    umbral_alto = 8'd4; umbral_bajo = 8'd3;
    #1;
    check("thr alto=count", 32'(almost_full), 32'd1);
    check("thr bajo<count", 32'(almost_empty), 32'd0);
    umbral_alto = 8'd3; umbral_bajo = 8'd1;

    // Drain
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain data", 32'(data_out), 32'(i + 1));
      check("drain valid", 32'(valid_out), 32'd1);
    end
    rd_en = 1'b0;
    step();
    check("drain valid drop", 32'(valid_out), 32'd0);
    check("drain data hold", 32'(data_out), 32'h04);
    check("drain empty", 32'(fifo_empty), 32'd1);
    check("drain error sticky", 32'(fifo_error), 32'd1);

    // Thresholds at count=0
    umbral_alto = 8'd0; umbral_bajo = 8'd0;
    #1;
    check("thr alto=0", 32'(almost_full), 32'd1);
    check("thr bajo=0", 32'(almost_empty), 32'd1);
    umbral_alto = 8'd3; umbral_bajo = 8'd1;

    // Underflow with simultaneous write
    reset = 1'b0; #1;
    check("rst2 error", 32'(fifo_error), 32'd0);
    reset = 1'b1;
    step();
    rd_en = 1'b1; wr_en = 1'b1; data_in = 6'h2A;
    step();
    check("udf valid", 32'(valid_out), 32'd0);
    check("udf error", 32'(fifo_error), 32'd1);
    check("udf count", 32'(count), 32'd1);
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    check("udf readback", 32'(data_out), 32'h2A);
    check("udf readback valid", 32'(valid_out), 32'd1);
    check("udf count after", 32'(count), 32'd0);

    // Simultaneous read/write with wrap
    reset = 1'b0; #1; reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 6'(i + 1);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_in = 6'(8'h10 + k);
      step();
      check("rw data", 32'(data_out), 32'(exp_rw[k]));
      check("rw valid", 32'(valid_out), 32'd1);
      check("rw count", 32'(count), 32'd4);
      check("rw error", 32'(fifo_error), 32'd0);
    end
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    check("wrap read", 32'(data_out), 32'h12);
    check("wrap count", 32'(count), 32'd3);

    // Asynchronous reset between edges with count=3
    #3 reset = 1'b0;
    #1;
    check_reset_state("async rst");
    reset = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post rst valid", 32'(valid_out), 32'd0);
    check("post rst error", 32'(fifo_error), 32'd1);
    check("post rst count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Parameterised synchronous FIFO that sits directly downstream of the FSM configuration block. It buffers one data/virtual-channel lane and compares its fill level against the 8-bit almost-full/almost-empty thresholds programmed by the FSM (UMF_OUT / UD_OUT). It reports empty and sticky-error status back to the FSM on one bit each of the FSM's FIFO_EMPTY / FIFO_ERROR buses. Five instances, one per FIFO, make up those 5-bit buses.

## Interface
- DATA_WIDTH, 6: width of stored words.
- ADDR_WIDTH, 2: pointer width; DEPTH = 2**ADDR_WIDTH (default 4); legal range 1..7.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- wr_en  input  1  write request; data_in stored at edge if accepted.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- umbral_alto  input  8  almost-full threshold (from FSM UMF_OUT).
- umbral_bajo  input  8  almost-empty threshold (from FSM UD_OUT).
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped at the last edge.
- fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0 (drives FIFO_EMPTY[i]).
- almost_full  output  1  count >= umbral_alto.
- almost_empty  output  1  count <= umbral_bajo.
- fifo_error  output  1  sticky overflow/underflow flag (drives FIFO_ERROR[i]).
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry register array with a write pointer and a read pointer, each ADDR_WIDTH bits. Pointers wrap modulo DEPTH; wrap-around needs no special handling.
- Occupancy is held in a separate count register of ADDR_WIDTH+1 bits.
- **Write accepted** when wr_en=1 and (count<DEPTH or a read is accepted in the same cycle). The word goes to mem[wr_ptr] and wr_ptr increments.
- **Read accepted** when rd_en=1 and count>0. data_out <= mem[rd_ptr], rd_ptr increments, valid_out=1 for the following cycle.
- **Count update:** +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- **Overflow:** wr_en=1, count==DEPTH, no accepted read. The word is dropped, pointers and count are unchanged, fifo_error is set.
- **Underflow:** rd_en=1, count==0. The read is ignored, valid_out=0, data_out holds, fifo_error is set. A simultaneous write is still accepted (count 0→1).
- **Full with wr_en=1 and rd_en=1:** both are accepted, count stays DEPTH, no error.
- fifo_error is sticky. Once set it stays 1 until reset; only reset clears it.
- **Threshold compares:** count is zero-extended to 8 bits. Compares are combinational from the count register and current threshold inputs, so a threshold change takes effect in the same cycle.
- **Threshold edge cases:**
  - umbral_alto=0 forces almost_full=1.
  - umbral_alto>DEPTH forces almost_full=0.
  - umbral_bajo>=DEPTH forces almost_empty=1.

## Timing
- **Reset (reset=0):** takes effect immediately without waiting for clk, including mid-operation; in-flight data is discarded.
  - Registers: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, fifo_error=0.
  - Derived outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full = (umbral_alto==0).
  - Memory contents are don't-care.
- First edge after reset deasserts behaves normally.
- **Write latency:** a word written at edge N is readable by an rd_en sampled at edge N+1 (no fall-through).
- **Read latency:** rd_en sampled at edge N gives data_out/valid_out valid after edge N, for exactly one cycle. valid_out drops at edge N+1 unless another read is accepted.
- **Flags:** count, fifo_full, fifo_empty, almost_* reflect the edge just taken. Overflow or underflow at edge N shows fifo_error=1 after edge N.
- No combinational path from wr_en/rd_en to any output.

## Test plan
- **Reset values:** reset=0 for 2 cycles with umbral_alto=3, umbral_bajo=1 → count=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fifo_error=0, valid_out=0, data_out=0.
- **Fill:** write 0x01,0x02,0x03,0x04 on consecutive edges with umbral_alto=3, umbral_bajo=1.
  - count steps 1,2,3,4.
  - almost_empty drops after the 2nd write, almost_full rises after the 3rd, fifo_full rises after the 4th.
- **Overflow then drain:** write 0x05 while full → dropped, fifo_error=1 after that edge, count=4. Then four reads → data_out 0x01,0x02,0x03,0x04 each with valid_out=1, fifo_empty=1 at end, fifo_error still 1.
- **Underflow:** after reset, rd_en=1 with wr_en=1, data_in=0x2A → valid_out=0, fifo_error=1, count=1. Next read returns 0x2A.
- **Simultaneous read/write and wrap:**
  - Fill 4, then 6 cycles of wr_en=rd_en=1 with data 0x10..0x15 → count stays 4, no error.
  - Outputs are 0x01..0x04 then 0x10,0x11 (pointers wrapped).
- **Reset mid-operation:** reset=0 asynchronously between edges with count=3 → all outputs return to reset values before the next edge. After release, a read returns nothing (underflow flagged).
